// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and shared types
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/alu_core_if.sv
// rtl/alu_core_if.sv - operand/control/result bundle between datapath and ALU
interface alu_core_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUCtr;
  logic [WIDTH-1:0] ALURes;
  logic             Zero;

  modport master (output SrcA, output SrcB, output ALUCtr, input ALURes, input Zero);
  modport slave  (input SrcA, input SrcB, input ALUCtr, output ALURes, output Zero);
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational logarithmic barrel shifter, logical left/right
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  shift_dir_e       dir_i,
  output logic [WIDTH-1:0] data_o
);

  // stage[s] holds the value after applying shift bits [s-1:0]
  logic [SHW:0][WIDTH-1:0] stage;

  assign stage[0] = data_i;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    always_comb begin
      stage[s+1] = stage[s];
      if (shamt_i[s]) begin
        if (dir_i == SHIFT_LEFT) stage[s+1] = stage[s] << (1 << s);
        else                     stage[s+1] = stage[s] >> (1 << s);
      end
    end
  end

  assign data_o = stage[SHW];

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit MIPS ALU with registered result and zero flag
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] alu_res_d, alu_res_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] shift_res;
  shift_dir_e       shift_dir;

  assign shift_dir = (bus.ALUCtr == ALU_SRL) ? SHIFT_RIGHT : SHIFT_LEFT;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .data_i  (bus.SrcB),
    .shamt_i (bus.SrcA[SHW-1:0]),
    .dir_i   (shift_dir),
    .data_o  (shift_res)
  );

  // Unlisted or unknown codes fall to default and produce zero
  always_comb begin
    alu_res_d = '0;
    case (bus.ALUCtr)
      ALU_AND: alu_res_d = bus.SrcA & bus.SrcB;
      ALU_OR:  alu_res_d = bus.SrcA | bus.SrcB;
      ALU_ADD: alu_res_d = bus.SrcA + bus.SrcB;
      ALU_SUB: alu_res_d = bus.SrcA - bus.SrcB;
      ALU_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      ALU_SLL: alu_res_d = shift_res;
      ALU_SRL: alu_res_d = shift_res;
      ALU_NOR: alu_res_d = ~(bus.SrcA | bus.SrcB);
      ALU_XOR: alu_res_d = bus.SrcA ^ bus.SrcB;
      default: alu_res_d = '0;
    endcase
  end

  // Flag derived from the same next-state value so it never lags the result
  assign zero_d = (alu_res_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      alu_res_q <= alu_res_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.ALURes = alu_res_q;
  assign bus.Zero   = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core
module tb_alu_core;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [63:0] wide;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  begin wide = {32'd0, a} + {32'd0, b}; return wide[31:0]; end
      4'd6:  begin wide = {32'd0, a} - {32'd0, b}; return wide[31:0]; end
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return b << (a % 32);
      4'd9:  return b >> (a % 32);
      4'd12: return ~(a | b);
      4'd13: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.ALUCtr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.SrcA = 32'hdead_beef; bus.SrcB = 32'h1; bus.ALUCtr = ALU_ADD;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ALURes !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: got res=%h zero=%b want res=00000000 zero=1", bus.ALURes, bus.Zero);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ALURes !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: got res=%h zero=%b want res=00000000 zero=1", bus.ALURes, bus.Zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] va [22] = '{32'hf0f0ffff, 32'hf0f0ffff, 32'hf0f0ffff, 32'hf0f0ffff, 32'hf0f0ffff,
                             32'h00000fff, 32'h0000f0f0, 32'h12345678, 32'h12345678,
                             32'h00000004, 32'h0000001f, 32'h00000000, 32'h12345678,
                             32'h00000005, 32'hffffffff, 32'h80000000, 32'h7fffffff,
                             32'h00000025, 32'h00000020, 32'h00000000, 32'hffffffff,
                             32'h7fffffff};
    logic [31:0] vb [22] = '{32'h0000f0f0, 32'h0000f0f0, 32'h0000f0f0, 32'h0000f0f0, 32'h0000f0f0,
                             32'h0000f0f0, 32'h00000fff, 32'h9abcdef0, 32'h9abcdef0,
                             32'h0000000f, 32'h80000000, 32'h00000000, 32'h12345678,
                             32'h00000005, 32'h00000001, 32'h7fffffff, 32'h80000000,
                             32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001,
                             32'h00000001};
    logic [3:0]  vc [22] = '{ALU_AND, ALU_ADD, ALU_SUB, ALU_OR, ALU_SLT,
                             ALU_SLT, ALU_SLT, 4'b1111, 4'b0011,
                             ALU_SLL, ALU_SRL, ALU_NOR, ALU_XOR,
                             ALU_SUB, ALU_ADD, ALU_SLT, ALU_SLT,
                             ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLT,
                             ALU_ADD};
    logic [31:0] ve [22] = '{32'h0000f0f0, 32'hf0f1f0ef, 32'hf0f00f0f, 32'hf0f0ffff, 32'h00000001,
                             32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000,
                             32'h000000f0, 32'h00000001, 32'hffffffff, 32'h00000000,
                             32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000,
                             32'h00000020, 32'h00000001, 32'h00000000, 32'h00000001,
                             32'h80000000};
    for (int i = 0; i < 22; i++) begin
      apply(va[i], vb[i], vc[i]);
      n_cmp++;
      if (bus.ALURes !== ve[i] || bus.Zero !== (ve[i] == 32'h0)) begin
        n_fail++;
        $display("FAIL vector_%0d ctr=%b a=%h b=%h: got res=%h zero=%b want res=%h zero=%b",
                 i, vc[i], va[i], vb[i], bus.ALURes, bus.Zero, ve[i], (ve[i] == 32'h0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    logic [3:0]  c;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = (i % 7 == 0) ? a : $urandom;
      if (i % 5 == 0) a = {$urandom_range(1, 0), 31'(a)};
      c = 4'($urandom_range(15, 0));
      exp = model(a, b, c);
      apply(a, b, c);
      n_cmp++;
      if (bus.ALURes !== exp || bus.Zero !== (exp == 32'h0)) begin
        n_fail++;
        $display("FAIL random_%0d ctr=%b a=%h b=%h: got res=%h zero=%b want res=%h zero=%b",
                 i, c, a, b, bus.ALURes, bus.Zero, exp, (exp == 32'h0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp;
    logic [3:0]  c;
    logic [3:0]  codes [9] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
                               ALU_SLL, ALU_SRL, ALU_NOR, ALU_XOR};
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      c = codes[i % 9];
      exp = model(a, b, c);
      apply(a, b, c);
      n_cmp++;
      if (bus.ALURes !== exp) begin
        n_fail++;
        $display("FAIL b2b_%0d ctr=%b: got res=%h want res=%h", i, c, bus.ALURes, exp);
      end
      // change inputs mid-cycle; registered output must not follow them
      bus.SrcA = ~a;
      bus.SrcB = ~b;
      #4;
      n_cmp++;
      if (bus.ALURes !== exp) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: got res=%h want res=%h", i, bus.ALURes, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    apply(32'h00001234, 32'h00000001, ALU_ADD);
    n_cmp++;
    if (bus.ALURes !== 32'h00001235 || bus.Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset: got res=%h zero=%b want res=00001235 zero=0", bus.ALURes, bus.Zero);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ALURes !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL midcycle_reset: got res=%h zero=%b want res=00000000 zero=1", bus.ALURes, bus.Zero);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ALURes !== 32'h0 || bus.Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_over_edge: got res=%h zero=%b want res=00000000 zero=1", bus.ALURes, bus.Zero);
    end
    #2 rst = 1'b0;
    apply(32'h000000ff, 32'h0000000f, ALU_XOR);
    n_cmp++;
    if (bus.ALURes !== 32'h000000f0 || bus.Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got res=%h zero=%b want res=000000f0 zero=0", bus.ALURes, bus.Zero);
    end
  endtask

  initial begin
    bus.SrcA = '0; bus.SrcB = '0; bus.ALUCtr = '0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
